// File: rtl/matmul_pkg.sv
// Shared definitions for the parametrised matrix-multiply engine.
//   state_t   : controller states, also exported on the debug port
//   fix_t     : result of range_fix (overflow flag + range-corrected sum)
//   range_fix : checks a wide partial sum against an acc_w-bit signed or
//               unsigned range, then clamps it (sat) or passes it through
//               so the caller can keep the low acc_w bits (wrap)
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Wide working width for the accumulate; holds any 2*DATA_W product plus
  // an ACC_W running sum for every supported configuration.
  localparam int CALC_W = 64;

  typedef struct packed {
    logic              ovf;
    logic [CALC_W-1:0] value;
  } fix_t;

  function automatic fix_t range_fix(input logic signed [CALC_W-1:0] sum,
                                     input int acc_w,
                                     input logic sgn,
                                     input logic sat);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    fix_t r;
    if (sgn) begin
      hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (acc_w - 1));
    end else begin
      hi = (64'sd1 <<< acc_w) - 64'sd1;
      lo = 64'sd0;
    end
    r.ovf = (sum > hi) || (sum < lo);
    if (r.ovf && sat) r.value = (sum > hi) ? hi : lo;
    else              r.value = sum;
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath shared by every C element.
//   clk, reset : clock, asynchronous active-low reset
//   en         : update the running sum this cycle
//   clear      : start a new dot product (previous sum treated as 0)
//   sgn, sat   : two's-complement operands / saturating accumulate
//   a, b       : operand elements
//   sum        : next running sum (range-corrected, combinational)
//   ovf        : this accumulate left the ACC_W range (combinational)
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic              sgn,
  input  logic              sat,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0]         acc;
  logic signed [CALC_W-1:0] a_x;
  logic signed [CALC_W-1:0] b_x;
  logic signed [CALC_W-1:0] acc_x;
  logic signed [CALC_W-1:0] total;
  fix_t                     fix;
  logic                     unused_hi;

  always_comb begin
    a_x   = {{(CALC_W-DATA_W){sgn & a[DATA_W-1]}}, a};
    b_x   = {{(CALC_W-DATA_W){sgn & b[DATA_W-1]}}, b};
    // The stored sum is reinterpreted per mode, so wrapped values keep
    // their modular meaning across the dot product.
    acc_x = clear ? '0 : {{(CALC_W-ACC_W){sgn & acc[ACC_W-1]}}, acc};
    total = acc_x + a_x * b_x;
    fix   = range_fix(total, ACC_W, sgn, sat);
    sum   = fix.value[ACC_W-1:0];
    ovf   = fix.ovf;
  end

  assign unused_hi = ^fix.value[CALC_W-1:ACC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/matmul_engine_param.sv
// NxN matrix-multiply engine, C = A x B, row-major element storage.
//   load_*     : addressed operand write port (accepted only in IDLE)
//   start      : begin a run; signed_mode/sat_mode are captured with it
//   busy       : COMPUTE or DRAIN
//   res_*      : result stream, index order 0..N*N-1
//   overflow   : sticky per run, cleared when a start is accepted
//   done       : one-cycle pulse after the final result handshake
//   dbg_state  : controller state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1; the producer holds its payload unchanged while valid && !ready.
module matmul_engine_param
  import matmul_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  DATA_W = 8,
  parameter int  ACC_W  = 16,
  localparam int AW     = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              signed_mode,
  input  logic              sat_mode,
  input  logic              start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [AW-1:0]     res_index,
  output logic              overflow,
  output logic              done,
  output state_t            dbg_state
);

  localparam int            CW       = $clog2(N);
  localparam logic [AW:0]   NUM_EL   = (AW+1)'(N*N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N*N-1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N-1);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   mat_a [N*N];
  logic [DATA_W-1:0]   mat_b [N*N];
  logic [ACC_W-1:0]    mat_c [N*N];
  logic [CW-1:0]       row, col, k;
  logic [AW-1:0]       rd_idx;
  logic [AW-1:0]       a_idx, b_idx, c_idx;
  logic                mode_sgn, mode_sat;
  logic                last_k, last_col, last_row;
  logic                compute_en, load_fire;
  logic [ACC_W-1:0]    mac_sum;
  logic                mac_ovf;

  assign last_k     = (k == LAST_CNT);
  assign last_col   = (col == LAST_CNT);
  assign last_row   = (row == LAST_CNT);
  assign compute_en = (state == COMPUTE);
  assign load_fire  = load_valid && load_ready && ({1'b0, load_addr} < NUM_EL);

  always_comb begin
    a_idx = AW'(32'(row) * N + 32'(k));
    b_idx = AW'(32'(k) * N + 32'(col));
    c_idx = AW'(32'(row) * N + 32'(col));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake/status outputs
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (start) state_nx = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_k && last_col && last_row) state_nx = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready && rd_idx == LAST_IDX) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // C is cleared on reset and rd_idx rests at 0, so the result port shows
  // zero until a run has written something.
  assign res_data  = mat_c[rd_idx];
  assign res_index = rd_idx;
  assign dbg_state = state;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (compute_en),
    .clear (k == '0),
    .sgn   (mode_sgn),
    .sat   (mode_sat),
    .a     (mat_a[a_idx]),
    .b     (mat_b[b_idx]),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N*N; i++) begin
        mat_a[i] <= '0;
        mat_b[i] <= '0;
        mat_c[i] <= '0;
      end
      row      <= '0;
      col      <= '0;
      k        <= '0;
      rd_idx   <= '0;
      mode_sgn <= 1'b0;
      mode_sat <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // A load coinciding with start lands before the first MAC read.
      if (load_fire) begin
        if (load_sel) mat_b[load_addr] <= load_data;
        else          mat_a[load_addr] <= load_data;
      end
      if (state == IDLE && start) begin
        row      <= '0;
        col      <= '0;
        k        <= '0;
        rd_idx   <= '0;
        overflow <= 1'b0;
        mode_sgn <= signed_mode;
        mode_sat <= sat_mode;
      end
      if (compute_en) begin
        if (mac_ovf) overflow <= 1'b1;
        if (last_k) begin
          mat_c[c_idx] <= mac_sum;
          k            <= '0;
          if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end
      if (state == DRAIN && res_ready) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_engine_param.sv
module tb_matmul_engine_param;
  import matmul_pkg::*;

  localparam int N   = 4;
  localparam int NN  = N * N;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;
  logic        signed_mode;
  logic        sat_mode;
  logic        start;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_index;
  logic        overflow;
  logic        done;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ma [NN];
  logic [7:0]  mb [NN];
  logic [15:0] exp_q [$];

  matmul_engine_param #(.N(N), .DATA_W(8), .ACC_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_sel    (load_sel),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .signed_mode (signed_mode),
    .sat_mode    (sat_mode),
    .start       (start),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_index   (res_index),
    .overflow    (overflow),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c], each partial sum range-checked
  // against 16-bit signed/unsigned limits, clamped or reduced mod 2^16.
  function automatic void model(input bit sgn, input bit sat, output bit ovf);
    longint hi, lo, acc, s, av, bv;
    hi  = sgn ? 32767 : 65535;
    lo  = sgn ? -32768 : 0;
    ovf = 1'b0;
    exp_q.delete();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          av = longint'(ma[r*N+k]);
          bv = longint'(mb[k*N+c]);
          if (sgn && av > 127) av -= 256;
          if (sgn && bv > 127) bv -= 256;
          s = acc + av * bv;
          if (s > hi || s < lo) begin
            ovf = 1'b1;
            if (sat) s = (s > hi) ? hi : lo;
            else begin
              s = s & 65535;
              if (sgn && s > 32767) s -= 65536;
            end
          end
          acc = s;
        end
        exp_q.push_back(acc[15:0]);
      end
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_all();
    for (int i = 0; i < 2*NN; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_sel   = (i >= NN);
      load_addr  = 4'(i % NN);
      load_data  = (i >= NN) ? mb[i-NN] : ma[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // One complete run: start, count compute cycles, drain with optional
  // backpressure against the scoreboard, then check the done pulse.
  task automatic run_and_check(input bit sgn, input bit sat, input bit bp,
                               input bit disturb, input bit ld_with_start, input string tag);
    bit          exp_ovf;
    int          cnt;
    int          idx;
    int          guard;
    bit          held;
    logic [15:0] hold_d;
    logic [3:0]  hold_i;
    logic [15:0] exp_d;
    if (ld_with_start) mb[5] = 8'($urandom_range(0, 255));
    model(sgn, sat, exp_ovf);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = sgn;
    sat_mode    = sat;
    if (ld_with_start) begin
      load_valid = 1'b1;
      load_sel   = 1'b1;
      load_addr  = 4'd5;
      load_data  = mb[5];
    end
    @(negedge clk);
    start       = 1'b0;
    load_valid  = 1'b0;
    signed_mode = 1'($urandom);
    sat_mode    = 1'($urandom);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_load_ready_compute"}, 32'(load_ready), 32'd0);
    cnt = 0;
    while (!res_valid && cnt < 200) begin
      cnt++;
      if (disturb && cnt == 10) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_sel   = 1'($urandom);
        load_addr  = 4'($urandom);
        load_data  = 8'($urandom);
        check({tag, "_load_ready_disturb"}, 32'(load_ready), 32'd0);
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      @(negedge clk);
    end
    start      = 1'b0;
    load_valid = 1'b0;
    check({tag, "_compute_cycles"}, 32'(cnt), 32'd64);
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    idx   = 0;
    guard = 0;
    held  = 1'b0;
    while (idx < NN && guard < 2000) begin
      guard++;
      if (held) begin
        check({tag, "_hold_data"}, 32'(res_data), 32'(hold_d));
        check({tag, "_hold_index"}, 32'(res_index), 32'(hold_i));
      end
      res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_ready) begin
        exp_d = exp_q.pop_front();
        check($sformatf("%s_valid_%0d", tag, idx), 32'(res_valid), 32'd1);
        check($sformatf("%s_data_%0d", tag, idx), 32'(res_data), 32'(exp_d));
        check($sformatf("%s_index_%0d", tag, idx), 32'(res_index), 32'(idx));
        idx++;
      end
      held   = !res_ready;
      hold_d = res_data;
      hold_i = res_index;
      @(negedge clk);
    end
    res_ready = 1'b0;
    check({tag, "_drain_words"}, 32'(idx), 32'(NN));
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_valid"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    reset       = 1'b0;
    load_valid  = 1'b0;
    load_sel    = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    signed_mode = 1'b0;
    sat_mode    = 1'b0;
    start       = 1'b0;
    res_ready   = 1'b0;
    for (int i = 0; i < NN; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end

    // Reset state
    apply_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_index", 32'(res_index), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Identity times 1..16
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i / N == i % N) ? 8'd1 : 8'd0;
      mb[i] = 8'(i + 1);
    end
    load_all();
    run_and_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ident");

    // All 255, unsigned wrap and saturate
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'hFF;
      mb[i] = 8'hFF;
    end
    load_all();
    run_and_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "u255_wrap");
    run_and_check(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "u255_sat");

    // Signed -128 saturate, then -1 x 1
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'h80;
      mb[i] = 8'h80;
    end
    load_all();
    run_and_check(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s128_sat");
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'hFF;
      mb[i] = 8'h01;
    end
    load_all();
    run_and_check(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sneg1");

    // Random operands under backpressure, both modes
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'($urandom_range(0, 255));
      mb[i] = 8'($urandom_range(0, 255));
    end
    load_all();
    run_and_check(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rand_s_sat_bp");
    run_and_check(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rand_u_wrap_bp");

    // Start/load pulsed during compute, then rerun without reloads,
    // then a load issued together with start
    run_and_check(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "disturb");
    run_and_check(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rerun");
    run_and_check(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "load_with_start");

    // Reset in the middle of a saturating run
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'hFF;
      mb[i] = 8'hFF;
    end
    load_all();
    @(negedge clk);
    start    = 1'b1;
    sat_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    while (cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("midrun_overflow_set", 32'(overflow), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_res_valid", 32'(res_valid), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_overflow", 32'(overflow), 32'd0);
    check("midrun_rst_res_data", 32'(res_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NN; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    run_and_check(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst_cleared");
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'($urandom_range(0, 255));
      mb[i] = 8'($urandom_range(0, 255));
    end
    load_all();
    run_and_check(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "after_rst_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
